aes256_key_schedule: RTL and testbench
======================================

Name: aes256_key_schedule

Overview:
- Sequential AES-256 key schedule driver. Accepts a 256-bit cipher key over a valid/ready handshake, then streams all 15 round keys (0..14) in order, one per accepted beat.
- Round keys 2..14 are produced by iterating one aes256_key_expansion_port over a 256-bit sliding window.
- Sits between the key-load interface and the round-key consumer (cipher core or round-key RAM).

Parameters:
- NUM_ROUNDS, 14, last round-key index; fixed for AES-256, exposed for assertions only.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Key  in  256  cipher key. Byte 0 at [7:0]; word k at [32k+31:32k].
- Key_valid  in  1  Key is valid.
- Key_ready  out  1  block can accept a key; high only in IDLE.
- Round_key  out  128  current round key, same byte/word order as Key.
- Round_key_number  out  4  index of Round_key, 0..14.
- Round_key_valid  out  1  Round_key is valid.
- Round_key_ready  in  1  consumer accepts Round_key.
- Round_key_last  out  1  high with Round_key_number==14.
- Busy  out  1  high in EMIT.

Behaviour:
- Clocking and reset: one clock. Rst is synchronous and active-high.
  - On Rst: state=IDLE, Round_key_valid=0, Round_key_last=0, Busy=0, Key_ready=1 (combinational from state), Round_key_number=0, window=0, Round_key=0.
- States:
  - IDLE: Key_ready=1. Key_valid&&Key_ready captures Key into the 256-bit window W (W[127:0]=words 0..3, W[255:128]=words 4..7). Round_key<=Key[127:0], number<=0, valid<=1, next state EMIT.
  - EMIT: Round_key_valid=1. A beat is accepted when Round_key_valid&&Round_key_ready.
    - On acceptance of number n<14: number<=n+1.
    - If n+1==1: Round_key<=W[255:128]; W unchanged.
    - If n+1>=2: the sub-module receives Round_number=n+1 and Input_key=W, and produces K. Then Round_key<=K and W<={K, W[255:128]}.
    - On acceptance of n==14: valid<=0, state<=IDLE.
  - Without acceptance, all outputs and W hold stable. This is a strict valid/ready stream: no output change while valid&&!ready.
- Latency and throughput:
  - Key accepted at edge N → key 0 valid after N.
  - With Round_key_ready held high, 15 beats on 15 consecutive cycles, then Key_ready=1 on the following cycle.
  - Minimum key-to-key period is 16 cycles.
- Round_key_last = Round_key_valid && (number==14).
- Key_valid in EMIT is ignored. Key is not sampled and not queued.
- Rst mid-EMIT aborts immediately. The next cycle shows IDLE outputs, and no partial keys resume.
- Simultaneous final-beat acceptance and Key_valid: the new key is not accepted that cycle because Key_ready=0. It is accepted in the next IDLE cycle.
- The number counter never exceeds 14 and does not wrap.
- Timing: one sub-module evaluation (SubWord + XOR chain) between registers. No combinational path from Round_key_ready or Key_valid to Round_key or W.

Decomposition:
- Shared package / aes_defines.svh holds: AES_256_KEY_LENGTH, AES_BLOCK_SIZE, AES_WORD_SIZE, AES_256_NUMBER_OF_ROUNDS, Rcon constants, and a typedef enum {IDLE, EMIT} for schedule state.
- One sub-module instance: aes256_key_expansion_port. Its Round_number input is driven from number+1, truncated to its declared width.

Test Plan:
- FIPS-197 AES-256 key bytes 00..1f, ready always 1 → 15 consecutive valid beats:
  - key0 = bytes 00..0f
  - key1 = bytes 10..1f
  - key2 = bytes a5 73 c2 9f a1 76 c4 98 a9 7f ce 93 a5 72 c0 9c
  - key14 = bytes 24 fc 79 cc bf 09 79 e9 37 1a c2 3c 6d 68 de 36, with Round_key_last=1
  - Key_ready=1 on the cycle after key14.
- Random backpressure (ready toggled ~50%) with the same key → identical 15-key sequence, and outputs are stable on every valid&&!ready cycle.
- Key_valid pulsed with key ff..ff during EMIT → ignored; the sequence continues for the first key.
- Rst asserted while number==7 → next cycle valid=0, Busy=0, Key_ready=1. A new key then restarts at number 0 with the correct key0.
- Back-to-back keys (all-zero key, then 00..1f) with Key_valid held high → the second key is accepted on the cycle after the first key's key14 beat.
  - For the all-zero key, key2 = bytes 62 63 63 63 62 63 63 63 62 63 63 63 62 63 63 63.
- Reset values → all outputs as listed in Behaviour on the cycle after Rst, with Key_valid=1 held during Rst producing no capture.

Source files
------------

// File: rtl/aes256_key_schedule_pkg.sv
// Shared AES-256 key-schedule constants, state type and byte-substitution helpers.
// Words are packed with byte 0 in the least significant byte.
package aes256_key_schedule_pkg;

  localparam int unsigned AES_256_KEY_LENGTH       = 256;
  localparam int unsigned AES_BLOCK_SIZE           = 128;
  localparam int unsigned AES_WORD_SIZE            = 32;
  localparam int unsigned AES_256_NUMBER_OF_ROUNDS = 14;
  localparam logic [3:0]  LAST_ROUND_NUM           = 4'd14;

  typedef enum logic {IDLE, EMIT} sched_state_t;

  // S-box entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes256_key_expansion_port.sv
// One AES-256 expansion step: derives the next four schedule words from the
// previous eight held in Input_key (word 0 at the bottom).
module aes256_key_expansion_port
  import aes256_key_schedule_pkg::*;
(
  input  logic [3:0]                    Round_number,
  input  logic [AES_256_KEY_LENGTH-1:0] Input_key,
  output logic [AES_BLOCK_SIZE-1:0]     Output_key
);

  logic [AES_WORD_SIZE-1:0] w_prev;
  logic [AES_WORD_SIZE-1:0] w_temp;
  logic [AES_WORD_SIZE-1:0] w_k0, w_k1, w_k2, w_k3;

  always_comb begin
    w_prev = Input_key[255:224];
    // Even rounds start on a multiple of eight words: RotWord + SubWord + Rcon.
    if (!Round_number[0]) begin
      w_temp = sub_word({w_prev[7:0], w_prev[31:8]}) ^ {24'h0, rcon(Round_number[3:1])};
    end else begin
      w_temp = sub_word(w_prev);
    end
    w_k0 = Input_key[31:0]   ^ w_temp;
    w_k1 = Input_key[63:32]  ^ w_k0;
    w_k2 = Input_key[95:64]  ^ w_k1;
    w_k3 = Input_key[127:96] ^ w_k2;
  end

  assign Output_key = {w_k3, w_k2, w_k1, w_k0};

endmodule

// File: rtl/aes256_key_schedule.sv
// Sequential AES-256 key schedule: loads a cipher key, then streams round keys
// 0..14 over a valid/ready interface using a 256-bit sliding window.
module aes256_key_schedule
  import aes256_key_schedule_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_256_NUMBER_OF_ROUNDS
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [255:0] Key,
  input  logic         Key_valid,
  output logic         Key_ready,
  output logic [127:0] Round_key,
  output logic [3:0]   Round_key_number,
  output logic         Round_key_valid,
  input  logic         Round_key_ready,
  output logic         Round_key_last,
  output logic         Busy
);

  sched_state_t r_state, w_state_nxt;
  logic [255:0] r_window, w_window_nxt;
  logic [127:0] r_round_key, w_round_key_nxt;
  logic [3:0]   r_number, w_number_nxt;
  logic         r_valid, w_valid_nxt;
  logic [3:0]   w_next_number;
  logic [127:0] w_expanded;

  assign w_next_number = r_number + 4'd1;

  aes256_key_expansion_port u_expand (
    .Round_number (w_next_number),
    .Input_key    (r_window),
    .Output_key   (w_expanded)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_window_nxt    = r_window;
    w_round_key_nxt = r_round_key;
    w_number_nxt    = r_number;
    w_valid_nxt     = r_valid;
    unique case (r_state)
      IDLE: begin
        if (Key_valid) begin
          w_window_nxt    = Key;
          w_round_key_nxt = Key[127:0];
          w_number_nxt    = 4'd0;
          w_valid_nxt     = 1'b1;
          w_state_nxt     = EMIT;
        end
      end
      EMIT: begin
        if (r_valid && Round_key_ready) begin
          if (r_number == LAST_ROUND_NUM) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_number_nxt = w_next_number;
            // Key 1 is the upper half of the cipher key; expansion starts at key 2.
            if (r_number == 4'd0) begin
              w_round_key_nxt = r_window[255:128];
            end else begin
              w_round_key_nxt = w_expanded;
              w_window_nxt    = {w_expanded, r_window[255:128]};
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_window    <= '0;
      r_round_key <= '0;
      r_number    <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_window    <= w_window_nxt;
      r_round_key <= w_round_key_nxt;
      r_number    <= w_number_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  assign Key_ready        = (r_state == IDLE);
  assign Busy             = (r_state == EMIT);
  assign Round_key        = r_round_key;
  assign Round_key_number = r_number;
  assign Round_key_valid  = r_valid;
  assign Round_key_last   = r_valid && (r_number == LAST_ROUND_NUM);

  a_number_bound: assert property (@(posedge Clk) disable iff (Rst)
    32'(r_number) <= NUM_ROUNDS);

endmodule

// File: tb/tb_aes256_key_schedule.sv
// Self-checking bench for aes256_key_schedule: FIPS-197 vectors plus a
// behavioural key-expansion model with a computed (GF-inverse) S-box.
module tb_aes256_key_schedule;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [255:0] Key;
  logic         Key_valid;
  logic         Key_ready;
  logic [127:0] Round_key;
  logic [3:0]   Round_key_number;
  logic         Round_key_valid;
  logic         Round_key_ready;
  logic         Round_key_last;
  logic         Busy;

  aes256_key_schedule #(.NUM_ROUNDS(14)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Key              (Key),
    .Key_valid        (Key_valid),
    .Key_ready        (Key_ready),
    .Round_key        (Round_key),
    .Round_key_number (Round_key_number),
    .Round_key_valid  (Round_key_valid),
    .Round_key_ready  (Round_key_ready),
    .Round_key_last   (Round_key_last),
    .Busy             (Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]   sb [256];
  logic [127:0] got_keys [15];

  typedef struct {
    logic [255:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] m_sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Full FIPS-197 expansion into 60 words, then pick the requested round key.
  function automatic logic [127:0] model_rk(input logic [255:0] k, input int r);
    logic [31:0] w [60];
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = m_sub_word({t[7:0], t[31:8]}) ^ {24'h0, rc};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = m_sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    return {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endfunction

  function automatic logic [127:0] le128(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [255:0] le256(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = v[8*(31-i) +: 8];
    return r;
  endfunction

  // Entered and left at a negedge; leaves Key_valid high when hold is set.
  task automatic start_key(input logic [255:0] k, input bit hold);
    int c = 0;
    while (!Key_ready && c < 50) begin
      @(negedge Clk);
      c++;
    end
    chk("key_ready_wait", 128'(Key_ready), 128'(1));
    Key       = k;
    Key_valid = 1'b1;
    @(negedge Clk);
    if (!hold) Key_valid = 1'b0;
  endtask

  // Streams one key's 15 beats, checking every valid cycle against the model.
  task automatic collect(input logic [255:0] k, input bit rnd, input bit pulse,
                         input bit b2b, input logic [255:0] k2);
    logic [127:0] exp [15];
    int n = 0;
    int cyc = 0;
    bit rdy;
    for (int r = 0; r < 15; r++) exp[r] = model_rk(k, r);
    while (n < 15 && cyc < 200) begin
      chk("beat_valid", 128'(Round_key_valid), 128'(1));
      chk("beat_number", 128'(Round_key_number), 128'(n));
      chk($sformatf("beat_key%0d", n), Round_key, exp[n]);
      chk("beat_last", 128'(Round_key_last), 128'(n == 14));
      chk("beat_busy", 128'(Busy), 128'(1));
      chk("beat_key_ready", 128'(Key_ready), 128'(0));
      rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      Round_key_ready = rdy;
      if (b2b) begin
        Key_valid = 1'b1;
        if (n == 14) Key = k2;
      end else if (pulse && n == 5) begin
        Key_valid = 1'b1;
        Key       = {256{1'b1}};
      end else begin
        Key_valid = 1'b0;
      end
      if (rdy) begin
        got_keys[n] = Round_key;
        n++;
      end
      cyc++;
      @(negedge Clk);
    end
    chk("beat_budget", 128'(n), 128'(15));
    Round_key_ready = 1'b1;
    chk("post_key_ready", 128'(Key_ready), 128'(1));
    chk("post_valid", 128'(Round_key_valid), 128'(0));
    chk("post_busy", 128'(Busy), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] fips_key;
    logic [255:0] zero_key;
    int c;
    fips_key = le256(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    zero_key = '0;
    build_sbox();
    vecs[0] = '{fips_key, 0,  le128(128'h000102030405060708090a0b0c0d0e0f)};
    vecs[1] = '{fips_key, 1,  le128(128'h101112131415161718191a1b1c1d1e1f)};
    vecs[2] = '{fips_key, 2,  le128(128'ha573c29fa176c498a97fce93a572c09c)};
    vecs[3] = '{fips_key, 14, le128(128'h24fc79ccbf0979e9371ac23c6d68de36)};
    vecs[4] = '{zero_key, 2,  le128(128'h62636363626363636263636362636363)};

    // Reset with Key_valid held: nothing may be captured.
    Rst             = 1'b1;
    Key             = fips_key;
    Key_valid       = 1'b1;
    Round_key_ready = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_key_ready", 128'(Key_ready), 128'(1));
    chk("rst_valid", 128'(Round_key_valid), 128'(0));
    chk("rst_last", 128'(Round_key_last), 128'(0));
    chk("rst_busy", 128'(Busy), 128'(0));
    chk("rst_number", 128'(Round_key_number), 128'(0));
    chk("rst_round_key", Round_key, 128'(0));
    Rst       = 1'b0;
    Key_valid = 1'b0;
    @(negedge Clk);
    chk("idle_valid", 128'(Round_key_valid), 128'(0));

    // FIPS / all-zero vectors, ready held high.
    for (int v = 0; v < 5; v++) begin
      start_key(vecs[v].key, 1'b0);
      collect(vecs[v].key, 1'b0, 1'b0, 1'b0, '0);
      chk($sformatf("vec%0d_key%0d", v, vecs[v].idx), got_keys[vecs[v].idx], vecs[v].exp);
    end

    // Random backpressure.
    start_key(fips_key, 1'b0);
    collect(fips_key, 1'b1, 1'b0, 1'b0, '0);
    chk("bp_key2", got_keys[2], vecs[2].exp);
    chk("bp_key14", got_keys[14], vecs[3].exp);

    // Key_valid pulsed with ff..ff mid-stream.
    start_key(fips_key, 1'b0);
    collect(fips_key, 1'b1, 1'b1, 1'b0, '0);
    chk("pulse_key14", got_keys[14], vecs[3].exp);

    // Reset at number 7, then a clean restart.
    start_key(fips_key, 1'b0);
    c = 0;
    while (Round_key_number != 4'd7 && c < 30) begin
      @(negedge Clk);
      c++;
    end
    chk("abort_at_7", 128'(Round_key_number), 128'(7));
    Rst = 1'b1;
    @(negedge Clk);
    chk("abort_valid", 128'(Round_key_valid), 128'(0));
    chk("abort_busy", 128'(Busy), 128'(0));
    chk("abort_key_ready", 128'(Key_ready), 128'(1));
    chk("abort_number", 128'(Round_key_number), 128'(0));
    Rst = 1'b0;
    start_key(fips_key, 1'b0);
    collect(fips_key, 1'b0, 1'b0, 1'b0, '0);
    chk("restart_key0", got_keys[0], vecs[0].exp);

    // Back-to-back: all-zero key then FIPS key with Key_valid held high.
    start_key(zero_key, 1'b1);
    collect(zero_key, 1'b0, 1'b0, 1'b1, fips_key);
    chk("b2b_zero_key2", got_keys[2], vecs[4].exp);
    @(negedge Clk);
    chk("b2b_second_captured", 128'(Round_key_valid), 128'(1));
    collect(fips_key, 1'b0, 1'b0, 1'b0, '0);
    chk("b2b_fips_key14", got_keys[14], vecs[3].exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
